mips5_pipeline_core: RTL and testbench
======================================

Name: mips5_pipeline_core

Overview:
- Single-issue, in-order, 5-stage (IF/ID/EX/MEM/WB) MIPS-subset integer core.
- Connects to an external single-cycle instruction RAM and data RAM. Both RAMs have combinational read, clocked write and are word-addressed.
- Contains the PC, a 32x32 register file, all pipeline registers, forwarding logic and hazard logic.
- Pipeline register names IF_ID_IR, ID_EX_*, EX_MEM_*, MEM_WB_*, WB_*, ex_stall_c and mem_stall_c are kept as named internal signals so benches can probe them hierarchically.

Parameters:
- ADDRESS_SIZE, 32, width of every memory address port; memories are indexed by word.
- DATA_SIZE, 32, width of instructions, data words and registers.

Ports:
- clock  in  1  single rising-edge clock.
- reset_n  in  1  synchronous, active-high reset. The signal is asserted when it is 1, despite the name.
- im_write_enable  out  1  held at 0; the core never writes instruction memory.
- im_write_address  out  ADDRESS_SIZE  held at 0.
- im_write_data  out  DATA_SIZE  held at 0.
- im_read_address  out  ADDRESS_SIZE  current PC.
- im_read_data  in  DATA_SIZE  instruction at the PC, combinational.
- dm_write_enable  out  1  store strobe, driven from MEM stage.
- dm_write_address  out  ADDRESS_SIZE  store word address (EX_MEM_result).
- dm_write_data  out  DATA_SIZE  store data (EX_MEM_B).
- dm_read_address  out  ADDRESS_SIZE  load word address (EX_MEM_result).
- dm_read_data  in  DATA_SIZE  load data, combinational.

Behaviour:
- Reset: while reset_n=1 at a clock edge:
  - PC=0, all register-file entries=0.
  - All pipeline registers=0, all *_valid=0, WB_WEenable=0.
  - dm_write_enable=0.
- Instruction word 0x00000000 is a NOP.
- Internal op encoding (4 bits): 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 ADDI, 7 LW, 8 SW, 9 BEQ, 10 J.
- Decode:
  - R-type (opcode 0), selected by funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - I-type opcodes: 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ.
  - J-type opcode: 0x02 J.
  - Any other encoding decodes to NOP.
- IF stage: IF_ID_IR <= im_read_data; PC <= PC+1 unless a stall or redirect occurs.
- ID stage:
  - Read rs and rt into ID_EX_A and ID_EX_B.
  - ID_EX_imm = sign-extended imm16.
  - ID_EX_rs, ID_EX_rt, ID_EX_rd = instruction fields; ID_EX_op = decoded op.
  - Register file is write-before-read: a WB write to the same register in the same cycle is seen by ID.
- EX stage:
  - ALU uses 32-bit wrapping add/sub; SLT is a signed compare yielding 1 or 0.
  - ADDI, LW and SW compute A+imm.
  - EX_MEM_dest = rd for R-type, rt for ADDI/LW, 0 otherwise.
  - EX_MEM_valid = 1 only for a non-NOP instruction.
- Forwarding into EX operands:
  - Priority: EX_MEM (non-load, valid, dest≠0) first, then MEM_WB/WB value (dest≠0), else the ID_EX value.
  - SW store data is forwarded the same way.
- MEM stage:
  - dm_write_enable = EX_MEM_valid && op==SW.
  - MEM_WB_data = dm_read_data; MEM_WB_result = EX_MEM_result.
  - mem_stall_c is constantly 0 (single-cycle memories).
- WB stage:
  - WB_value = MEM_WB_data for LW, else MEM_WB_result.
  - WB_dest = MEM_WB_dest.
  - WB_WEenable = MEM_WB_valid && dest≠0 && op writes a register; writes on the clock edge.
  - Register 0 always reads 0; writes to it are ignored.
- Load-use hazard:
  - Condition: ID_EX_op==LW and ID_EX_rt≠0 and ID_EX_rt equals the ID instruction's rs, or its rt when rt is a source.
  - Response: ex_stall_c=1 for exactly one cycle; PC and IF_ID_IR hold; a NOP bubble is inserted into ID/EX.
- J: resolved in ID. PC <= {PC+1 upper bits, 26-bit target}, truncated to ADDRESS_SIZE. IF_ID_IR is flushed to 0, giving 1 bubble.
- BEQ:
  - Resolved in EX using forwarded operands.
  - If taken: PC <= (branch PC)+1+imm; IF_ID_IR and ID_EX are flushed to NOP, giving 2 bubbles.
  - If not taken: no effect.
- Simultaneous events: a taken BEQ in EX has priority over a stall or J in ID; the stall is cancelled because the younger instruction is flushed.
- Reset asserted mid-program: all in-flight instructions are discarded the next edge; execution restarts at PC 0.
- PC wraps modulo 2^ADDRESS_SIZE.

Test Plan:
- Reset: hold reset_n=1 for 2 cycles, then 0 -> im_read_address=0 and all *_valid=0 during reset; PC increments 0,1,2… afterwards.
- Back-to-back forwarding: ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; SUB r4,r3,r1 -> r3=12 and r4=7, with no stall cycles.
- Load-use: SW r3,0(r0), then LW r5,0(r0); ADD r6,r5,r5 -> dm word 0=12; ex_stall_c high for 1 cycle; r6=24.
- BEQ taken: r1==r1, offset +2 -> the 2 younger instructions never write; PC jumps to branch+3. BEQ with unequal operands -> falls through.
- J to address 8 -> the instruction after J is squashed; fetch resumes at 8.
- r0 protection: ADDI r0,r0,9, then ADD r7,r0,r0 -> r7=0; WB_WEenable=0 for the first instruction.

Source files
------------

// File: rtl/mips5_pipeline_core.sv
// Five-stage in-order MIPS-subset core (IF/ID/EX/MEM/WB) with EX forwarding,
// load-use stall, J resolved in ID and BEQ resolved in EX.
module mips5_pipeline_core #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    output logic                    im_write_enable,
    output logic [ADDRESS_SIZE-1:0] im_write_address,
    output logic [DATA_SIZE-1:0]    im_write_data,
    output logic [ADDRESS_SIZE-1:0] im_read_address,
    input  logic [DATA_SIZE-1:0]    im_read_data,
    output logic                    dm_write_enable,
    output logic [ADDRESS_SIZE-1:0] dm_write_address,
    output logic [DATA_SIZE-1:0]    dm_write_data,
    output logic [ADDRESS_SIZE-1:0] dm_read_address,
    input  logic [DATA_SIZE-1:0]    dm_read_data
);
    localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                           OP_OR = 4'd4, OP_SLT = 4'd5, OP_ADDI = 4'd6, OP_LW = 4'd7,
                           OP_SW = 4'd8, OP_BEQ = 4'd9, OP_J = 4'd10;

    logic [ADDRESS_SIZE-1:0] pc, IF_ID_pc1, ID_EX_pc1, br_target, j_target;
    logic [DATA_SIZE-1:0]    IF_ID_IR;
    logic [DATA_SIZE-1:0]    ID_EX_A, ID_EX_B, ID_EX_imm;
    logic [4:0]              ID_EX_rs, ID_EX_rt, ID_EX_rd;
    logic [3:0]              ID_EX_op;
    logic                    ID_EX_valid;
    logic [DATA_SIZE-1:0]    EX_MEM_result, EX_MEM_B;
    logic [4:0]              EX_MEM_dest;
    logic [3:0]              EX_MEM_op;
    logic                    EX_MEM_valid;
    logic [DATA_SIZE-1:0]    MEM_WB_data, MEM_WB_result;
    logic [4:0]              MEM_WB_dest;
    logic [3:0]              MEM_WB_op;
    logic                    MEM_WB_valid;
    logic [DATA_SIZE-1:0]    WB_value;
    logic [4:0]              WB_dest;
    logic                    WB_WEenable;
    logic                    ex_stall_c, mem_stall_c;
    logic [DATA_SIZE-1:0]    rf [0:31];

    logic [4:0]           id_rs, id_rt, id_rd;
    logic [3:0]           id_op;
    logic                 id_rt_src, load_use, br_taken, j_redirect;
    logic [DATA_SIZE-1:0] id_a, id_b, id_imm, fwd_a, fwd_b, alu_out;
    logic [4:0]           ex_dest;

    assign im_write_enable  = 1'b0;
    assign im_write_address = '0;
    assign im_write_data    = '0;
    assign im_read_address  = pc;
    assign mem_stall_c      = 1'b0;

    assign id_rs  = IF_ID_IR[25:21];
    assign id_rt  = IF_ID_IR[20:16];
    assign id_rd  = IF_ID_IR[15:11];
    assign id_imm = {{(DATA_SIZE-16){IF_ID_IR[15]}}, IF_ID_IR[15:0]};

    always_comb begin
        id_op = OP_NOP;
        case (IF_ID_IR[31:26])
            6'h00: case (IF_ID_IR[5:0])
                6'h20:   id_op = OP_ADD;
                6'h22:   id_op = OP_SUB;
                6'h24:   id_op = OP_AND;
                6'h25:   id_op = OP_OR;
                6'h2A:   id_op = OP_SLT;
                default: id_op = OP_NOP;
            endcase
            6'h08:   id_op = OP_ADDI;
            6'h23:   id_op = OP_LW;
            6'h2B:   id_op = OP_SW;
            6'h04:   id_op = OP_BEQ;
            6'h02:   id_op = OP_J;
            default: id_op = OP_NOP;
        endcase
    end

    assign id_rt_src = (id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SW, OP_BEQ});

    // Register file is write-before-read: the WB value bypasses the array.
    assign id_a = (id_rs == 5'd0) ? '0 : (WB_WEenable && WB_dest == id_rs) ? WB_value : rf[id_rs];
    assign id_b = (id_rt == 5'd0) ? '0 : (WB_WEenable && WB_dest == id_rt) ? WB_value : rf[id_rt];

    assign load_use = ID_EX_valid && ID_EX_op == OP_LW && ID_EX_rt != 5'd0 &&
                      (ID_EX_rt == id_rs || (id_rt_src && ID_EX_rt == id_rt));

    // EX_MEM has priority; a load in EX_MEM has no data yet, so it is skipped.
    always_comb begin
        fwd_a = ID_EX_A;
        fwd_b = ID_EX_B;
        if (EX_MEM_valid && EX_MEM_op != OP_LW && EX_MEM_dest != 5'd0 && EX_MEM_dest == ID_EX_rs)
            fwd_a = EX_MEM_result;
        else if (WB_WEenable && WB_dest == ID_EX_rs)
            fwd_a = WB_value;
        if (EX_MEM_valid && EX_MEM_op != OP_LW && EX_MEM_dest != 5'd0 && EX_MEM_dest == ID_EX_rt)
            fwd_b = EX_MEM_result;
        else if (WB_WEenable && WB_dest == ID_EX_rt)
            fwd_b = WB_value;
    end

    always_comb begin
        alu_out = '0;
        ex_dest = 5'd0;
        case (ID_EX_op)
            OP_ADD: begin alu_out = fwd_a + fwd_b; ex_dest = ID_EX_rd; end
            OP_SUB: begin alu_out = fwd_a - fwd_b; ex_dest = ID_EX_rd; end
            OP_AND: begin alu_out = fwd_a & fwd_b; ex_dest = ID_EX_rd; end
            OP_OR:  begin alu_out = fwd_a | fwd_b; ex_dest = ID_EX_rd; end
            OP_SLT: begin
                alu_out = {{(DATA_SIZE-1){1'b0}}, ($signed(fwd_a) < $signed(fwd_b))};
                ex_dest = ID_EX_rd;
            end
            OP_ADDI, OP_LW: begin alu_out = fwd_a + ID_EX_imm; ex_dest = ID_EX_rt; end
            OP_SW:   alu_out = fwd_a + ID_EX_imm;
            default: alu_out = '0;
        endcase
    end

    assign br_taken   = ID_EX_valid && ID_EX_op == OP_BEQ && fwd_a == fwd_b;
    assign br_target  = ID_EX_pc1 + ADDRESS_SIZE'(ID_EX_imm);
    assign ex_stall_c = load_use && !br_taken;
    assign j_redirect = id_op == OP_J && !ex_stall_c && !br_taken;
    assign j_target   = {IF_ID_pc1[ADDRESS_SIZE-1:26], IF_ID_IR[25:0]};

    assign dm_write_enable  = !reset_n && EX_MEM_valid && EX_MEM_op == OP_SW;
    assign dm_write_address = ADDRESS_SIZE'(EX_MEM_result);
    assign dm_read_address  = ADDRESS_SIZE'(EX_MEM_result);
    assign dm_write_data    = EX_MEM_B;

    assign WB_value    = (MEM_WB_op == OP_LW) ? MEM_WB_data : MEM_WB_result;
    assign WB_dest     = MEM_WB_dest;
    assign WB_WEenable = !reset_n && MEM_WB_valid && MEM_WB_dest != 5'd0 &&
                         (MEM_WB_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_LW});

    always_ff @(posedge clock) begin
        if (reset_n) begin
            pc <= '0;
            IF_ID_IR <= '0; IF_ID_pc1 <= '0;
            ID_EX_A <= '0; ID_EX_B <= '0; ID_EX_imm <= '0; ID_EX_pc1 <= '0;
            ID_EX_rs <= '0; ID_EX_rt <= '0; ID_EX_rd <= '0; ID_EX_op <= OP_NOP; ID_EX_valid <= 1'b0;
            EX_MEM_result <= '0; EX_MEM_B <= '0; EX_MEM_dest <= '0; EX_MEM_op <= OP_NOP; EX_MEM_valid <= 1'b0;
            MEM_WB_data <= '0; MEM_WB_result <= '0; MEM_WB_dest <= '0; MEM_WB_op <= OP_NOP; MEM_WB_valid <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (WB_WEenable) rf[WB_dest] <= WB_value;

            if (br_taken) begin
                pc       <= br_target;
                IF_ID_IR <= '0;
            end else if (!(ex_stall_c || mem_stall_c)) begin
                if (j_redirect) begin
                    pc       <= j_target;
                    IF_ID_IR <= '0;
                end else begin
                    pc        <= pc + ADDRESS_SIZE'(1);
                    IF_ID_IR  <= im_read_data;
                    IF_ID_pc1 <= pc + ADDRESS_SIZE'(1);
                end
            end

            if (br_taken || ex_stall_c) begin
                ID_EX_op    <= OP_NOP;
                ID_EX_valid <= 1'b0;
            end else begin
                ID_EX_A <= id_a; ID_EX_B <= id_b; ID_EX_imm <= id_imm; ID_EX_pc1 <= IF_ID_pc1;
                ID_EX_rs <= id_rs; ID_EX_rt <= id_rt; ID_EX_rd <= id_rd;
                ID_EX_op <= id_op; ID_EX_valid <= (id_op != OP_NOP);
            end

            EX_MEM_result <= alu_out; EX_MEM_B <= fwd_b; EX_MEM_dest <= ex_dest;
            EX_MEM_op <= ID_EX_op; EX_MEM_valid <= ID_EX_valid;

            MEM_WB_data <= dm_read_data; MEM_WB_result <= EX_MEM_result; MEM_WB_dest <= EX_MEM_dest;
            MEM_WB_op <= EX_MEM_op; MEM_WB_valid <= EX_MEM_valid;
        end
    end
endmodule

// File: tb/tb_mips5_pipeline_core.sv
// Bench for mips5_pipeline_core: ALU vector table, directed hazard programs and
// random programs compared against an instruction-level interpreter.
module tb_mips5_pipeline_core;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        im_write_enable, dm_write_enable;
    logic [31:0] im_write_address, im_write_data, im_read_address, im_read_data;
    logic [31:0] dm_write_address, dm_write_data, dm_read_address, dm_read_data;

    logic [31:0] imem [256];
    logic [31:0] dmem [64];
    logic [31:0] dm_preset [64];
    logic [31:0] m_rf [32];
    logic [31:0] m_dm [64];
    int checks = 0, errors = 0, stall_cnt = 0, we_cnt = 0;

    always #5 clock = ~clock;

    mips5_pipeline_core #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .im_write_enable(im_write_enable), .im_write_address(im_write_address),
        .im_write_data(im_write_data), .im_read_address(im_read_address),
        .im_read_data(im_read_data), .dm_write_enable(dm_write_enable),
        .dm_write_address(dm_write_address), .dm_write_data(dm_write_data),
        .dm_read_address(dm_read_address), .dm_read_data(dm_read_data)
    );

    assign im_read_data = imem[im_read_address[7:0]];
    assign dm_read_data = dmem[dm_read_address[5:0]];

    // Data memory is reloaded from dm_preset while reset is held.
    always @(posedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < 64; i++) dmem[i] <= dm_preset[i];
        end else if (dm_write_enable) begin
            dmem[dm_write_address[5:0]] <= dm_write_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        for (int i = 0; i < 64; i++) dm_preset[i] = 32'h0;
    endtask

    task automatic do_reset();
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        stall_cnt = 0;
        we_cnt = 0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clock);
            stall_cnt += int'(dut.ex_stall_c);
            we_cnt += int'(dut.WB_WEenable);
        end
    endtask

    function automatic logic [31:0] valids();
        return {27'h0, dut.ID_EX_valid, dut.EX_MEM_valid, dut.MEM_WB_valid, dut.WB_WEenable, dm_write_enable};
    endfunction

    // Instruction-level interpreter: one instruction at a time, no pipeline.
    task automatic iss_run();
        int pc, steps, next;
        logic [31:0] ir, a, b, imm, addr;
        logic [4:0] rs, rt, rd;
        pc = 0;
        steps = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        while (pc < 48 && steps < 500) begin
            ir = imem[pc];
            rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
            a = m_rf[rs]; b = m_rf[rt];
            imm = {{16{ir[15]}}, ir[15:0]};
            addr = a + imm;
            next = pc + 1;
            case (ir[31:26])
                6'h00: case (ir[5:0])
                    6'h20: if (rd != 0) m_rf[rd] = a + b;
                    6'h22: if (rd != 0) m_rf[rd] = a - b;
                    6'h24: if (rd != 0) m_rf[rd] = a & b;
                    6'h25: if (rd != 0) m_rf[rd] = a | b;
                    6'h2A: if (rd != 0) m_rf[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: ;
                endcase
                6'h08: if (rt != 0) m_rf[rt] = addr;
                6'h23: if (rt != 0) m_rf[rt] = m_dm[addr[5:0]];
                6'h2B: m_dm[addr[5:0]] = b;
                6'h04: if (a == b) next = pc + 1 + int'($signed(imm));
                6'h02: next = int'(ir[25:0]);
                default: ;
            endcase
            pc = next;
            steps++;
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [10];

    initial begin
        logic [4:0] rs, rt, rd;
        logic [5:0] fn;
        int k;

        vecs[0] = '{32'h00221820, 32'h7FFFFFFF, 32'h00000001, 32'h80000000}; // ADD wrap
        vecs[1] = '{32'h00221822, 32'h00000000, 32'h00000001, 32'hFFFFFFFF}; // SUB wrap
        vecs[2] = '{32'h00221824, 32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F}; // AND
        vecs[3] = '{32'h00221825, 32'hF0000000, 32'h0000000F, 32'hF000000F}; // OR
        vecs[4] = '{32'h0022182A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001}; // SLT -1<1
        vecs[5] = '{32'h0022182A, 32'h00000001, 32'hFFFFFFFF, 32'h00000000}; // SLT 1<-1
        vecs[6] = '{32'h0022182A, 32'h00000005, 32'h00000005, 32'h00000000}; // SLT equal
        vecs[7] = '{32'h2023FFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF}; // ADDI -1
        vecs[8] = '{32'hFC221800, 32'h12345678, 32'h1, 32'h00000000};         // bad opcode
        vecs[9] = '{32'h00221821, 32'h12345678, 32'h1, 32'h00000000};         // bad funct

        // Reset and PC sequencing
        clear_prog();
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_pc_a", im_read_address, 32'd0);
        check("rst_valid_a", valids(), 32'd0);
        @(negedge clock);
        check("rst_pc_b", im_read_address, 32'd0);
        check("rst_valid_b", valids(), 32'd0);
        reset_n = 1'b0;
        check("pc0", im_read_address, 32'd0);
        @(negedge clock);
        check("pc1", im_read_address, 32'd1);
        @(negedge clock);
        check("pc2", im_read_address, 32'd2);
        check("im_write", {31'h0, im_write_enable} | im_write_address | im_write_data, 32'd0);

        // ALU vector table: operands loaded from memory into r1/r2, result in r3
        for (int i = 0; i < 10; i++) begin
            clear_prog();
            dm_preset[0] = vecs[i].a;
            dm_preset[1] = vecs[i].b;
            imem[0] = 32'h8C010000;
            imem[1] = 32'h8C020001;
            imem[2] = vecs[i].instr;
            do_reset();
            run(14);
            check($sformatf("vec%0d", i), dut.rf[3], vecs[i].exp);
        end

        // Forwarding then load-use
        clear_prog();
        imem[0] = 32'h20010005; imem[1] = 32'h20020007; imem[2] = 32'h00221820;
        imem[3] = 32'h00612022; imem[4] = 32'hAC030000; imem[5] = 32'h8C050000;
        imem[6] = 32'h00A53020;
        do_reset();
        run(20);
        check("fwd_r3", dut.rf[3], 32'd12);
        check("fwd_r4", dut.rf[4], 32'd7);
        check("lu_dm0", dmem[0], 32'd12);
        check("lu_r6", dut.rf[6], 32'd24);
        check("lu_stalls", stall_cnt, 32'd1);
        check("lu_writes", we_cnt, 32'd6);

        // Reset in mid-program restarts from PC 0
        do_reset();
        run(4);
        reset_n = 1'b1;
        @(negedge clock);
        check("mid_rst_pc", im_read_address, 32'd0);
        check("mid_rst_valid", valids(), 32'd0);
        check("mid_rst_rf", dut.rf[1], 32'd0);
        reset_n = 1'b0;
        run(20);
        check("mid_rst_r6", dut.rf[6], 32'd24);

        // BEQ taken: two younger instructions squashed
        clear_prog();
        imem[0] = 32'h20010003; imem[1] = 32'h10210002; imem[2] = 32'h20020001;
        imem[3] = 32'h20030001; imem[4] = 32'h20040004;
        do_reset();
        run(16);
        check("beq_t_r2", dut.rf[2], 32'd0);
        check("beq_t_r3", dut.rf[3], 32'd0);
        check("beq_t_r4", dut.rf[4], 32'd4);
        check("beq_t_writes", we_cnt, 32'd2);

        // BEQ not taken: falls through
        clear_prog();
        imem[0] = 32'h20010003; imem[1] = 32'h20020004; imem[2] = 32'h10220002;
        imem[3] = 32'h20030001; imem[4] = 32'h20040004;
        do_reset();
        run(16);
        check("beq_nt_r3", dut.rf[3], 32'd1);
        check("beq_nt_r4", dut.rf[4], 32'd4);

        // J to 8: instruction after J squashed
        clear_prog();
        imem[0] = 32'h08000008; imem[1] = 32'h20010001; imem[8] = 32'h20020002;
        do_reset();
        run(16);
        check("j_r1", dut.rf[1], 32'd0);
        check("j_r2", dut.rf[2], 32'd2);

        // r0 protection
        clear_prog();
        imem[0] = 32'h20000009; imem[1] = 32'h00003820;
        do_reset();
        run(12);
        check("r0_r0", dut.rf[0], 32'd0);
        check("r0_r7", dut.rf[7], 32'd0);
        check("r0_writes", we_cnt, 32'd1);

        // Random programs against the interpreter
        for (int p = 0; p < 6; p++) begin
            clear_prog();
            for (int i = 0; i < 16; i++) dm_preset[i] = $urandom;
            for (int i = 0; i < 64; i++) m_dm[i] = dm_preset[i];
            for (int i = 0; i < 40; i++) begin
                k = $urandom_range(0, 9);
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
                rd = 5'($urandom_range(0, 7));
                case (k)
                    0: fn = 6'h20;
                    1: fn = 6'h22;
                    2: fn = 6'h24;
                    3: fn = 6'h25;
                    default: fn = 6'h2A;
                endcase
                case (k)
                    0, 1, 2, 3, 4: imem[i] = {6'h00, rs, rt, rd, 5'h0, fn};
                    5: imem[i] = {6'h08, rs, rt, 16'($urandom)};
                    6: imem[i] = {6'h23, 5'd0, rt, 16'($urandom_range(0, 15))};
                    7: imem[i] = {6'h2B, 5'd0, rt, 16'($urandom_range(0, 15))};
                    8: imem[i] = {6'h04, rs, rt, 16'($urandom_range(0, 3))};
                    default: imem[i] = {6'h02, 26'(i + 1 + $urandom_range(1, 4))};
                endcase
            end
            iss_run();
            do_reset();
            run(200);
            for (int r = 1; r < 8; r++)
                check($sformatf("rand%0d_r%0d", p, r), dut.rf[r], m_rf[r]);
            for (int a = 0; a < 16; a++)
                check($sformatf("rand%0d_dm%0d", p, a), dmem[a], m_dm[a]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
